baccarat_sequencer: RTL and testbench

- Sequences one round of baccarat in the card-game datapath.
- Drives the six card-register load strobes in dealing order and applies the player and banker third-card rules to the scores from the player and dealer hand scorers.
- Once the last card is in, drives the win/tie lights.
- Advances at most one state per cycle, only when the debounced `step` pulse is high.

---
 rtl/baccarat_pkg.sv | 34 +++
 rtl/baccarat_sequencer_if.sv | 37 +++
 rtl/banker_draw_rule.sv | 27 ++
 rtl/baccarat_sequencer.sv | 95 +++++++++
 tb/tb_baccarat_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat round sequencer.
// Imported by the sequencer FSM, its interface and the banker third-card rule.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_EVAL1,
    S_P3,
    S_EVAL2,
    S_D3,
    S_DONE
  } state_t;

  localparam logic [3:0] CARD_EMPTY      = 4'd0;
  localparam logic [3:0] CARD_ACE        = 4'd1;
  localparam logic [3:0] CARD_KING       = 4'd13;
  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;

  // Point value of a raw card code: Ace..9 count face value, 10..King count zero.
  function automatic logic [3:0] card_value(input logic [3:0] card);
    logic [3:0] value;
    if (card >= CARD_ACE && card <= 4'd9) begin
      value = card;
    end else begin
      value = CARD_EMPTY;
    end
    return value;
  endfunction

endpackage

// File: rtl/baccarat_sequencer_if.sv
// Handshake between the round sequencer and the card datapath:
// step pulse and scores in, load strobes and result lights out.
interface baccarat_sequencer_if;

  logic       step;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;

  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;

  logic       player_win_light;
  logic       dealer_win_light;
  logic       done;

  // Sequencer side
  modport master (
    input  step, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, done
  );

  // Datapath side
  modport slave (
    output step, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, done
  );

endinterface

// File: rtl/banker_draw_rule.sv
// Banker third-card table: decides whether the banker draws, given the
// banker total and the player's third card.
module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  assign v = card_value(pcard3);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_sequencer.sv
// Moore FSM sequencing one baccarat round: deals six card slots in order,
// applies the third-card rules, then shows the win/tie lights.
module baccarat_sequencer
  import baccarat_pkg::*;
(
  input  logic                        slow_clock,
  input  logic                        resetb,
  baccarat_sequencer_if.master        bus
);

  state_t state_reg;
  state_t state_next;
  logic   banker_draw;

  banker_draw_rule u_banker_draw_rule (
    .dscore (bus.dscore),
    .pcard3 (bus.pcard3),
    .draw   (banker_draw)
  );

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_reg <= S_P1;
    end else begin
      state_reg <= state_next;
    end
  end

  // Scores lag the load strobe by one cycle, so decisions are taken only in
  // the EVAL states that follow each dealing state.
  always_comb begin
    state_next           = state_reg;
    bus.load_pcard1      = 1'b0;
    bus.load_pcard2      = 1'b0;
    bus.load_pcard3      = 1'b0;
    bus.load_dcard1      = 1'b0;
    bus.load_dcard2      = 1'b0;
    bus.load_dcard3      = 1'b0;
    bus.player_win_light = 1'b0;
    bus.dealer_win_light = 1'b0;
    bus.done             = 1'b0;

    case (state_reg)
      S_P1: begin
        bus.load_pcard1 = 1'b1;
        if (bus.step) state_next = S_D1;
      end
      S_D1: begin
        bus.load_dcard1 = 1'b1;
        if (bus.step) state_next = S_P2;
      end
      S_P2: begin
        bus.load_pcard2 = 1'b1;
        if (bus.step) state_next = S_D2;
      end
      S_D2: begin
        bus.load_dcard2 = 1'b1;
        if (bus.step) state_next = S_EVAL1;
      end
      S_EVAL1: begin
        if (bus.step) begin
          if (bus.pscore >= NATURAL_MIN || bus.dscore >= NATURAL_MIN) begin
            state_next = S_DONE;
          end else if (bus.pscore <= PLAYER_DRAW_MAX) begin
            state_next = S_P3;
          end else if (bus.dscore <= PLAYER_DRAW_MAX) begin
            state_next = S_D3;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_P3: begin
        bus.load_pcard3 = 1'b1;
        if (bus.step) state_next = S_EVAL2;
      end
      S_EVAL2: begin
        if (bus.step) state_next = banker_draw ? S_D3 : S_DONE;
      end
      S_D3: begin
        bus.load_dcard3 = 1'b1;
        if (bus.step) state_next = S_DONE;
      end
      S_DONE: begin
        bus.done             = 1'b1;
        bus.player_win_light = (bus.pscore >= bus.dscore);
        bus.dealer_win_light = (bus.dscore >= bus.pscore);
      end
      default: begin
        state_next = S_P1;
      end
    endcase
  end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Self-checking bench: plays rounds through a card datapath model and compares
// every cycle's outputs with a round-level baccarat reference model.
module tb_baccarat_sequencer;

  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;

  baccarat_sequencer_if bus();

  baccarat_sequencer dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus)
  );

  always #5 slow_clock = ~slow_clock;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Card datapath model: deal[] holds the cards for p1,d1,p2,d2,p3,d3
  logic [3:0] deal [6];
  logic [3:0] p1, p2, p3, d1, d2, d3;
  logic       force_en = 1'b0;
  logic [3:0] f_ps = 0, f_ds = 0, f_pc3 = 0;
  logic       step = 1'b0;

  function automatic int cval(input int c);
    return (c <= 9) ? c : 0;
  endfunction

  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      p1 <= 0; p2 <= 0; p3 <= 0; d1 <= 0; d2 <= 0; d3 <= 0;
    end else if (step) begin
      if (bus.load_pcard1) p1 <= deal[0];
      if (bus.load_dcard1) d1 <= deal[1];
      if (bus.load_pcard2) p2 <= deal[2];
      if (bus.load_dcard2) d2 <= deal[3];
      if (bus.load_pcard3) p3 <= deal[4];
      if (bus.load_dcard3) d3 <= deal[5];
    end
  end

  int ps_calc, ds_calc;
  assign ps_calc = (cval(p1) + cval(p2) + cval(p3)) % 10;
  assign ds_calc = (cval(d1) + cval(d2) + cval(d3)) % 10;

  assign bus.step   = step;
  assign bus.pscore = force_en ? f_ps  : 4'(ps_calc);
  assign bus.dscore = force_en ? f_ds  : 4'(ds_calc);
  assign bus.pcard3 = force_en ? f_pc3 : p3;

  // {done, pwin, dwin, lp1, ld1, lp2, ld2, lp3, ld3}
  function automatic int outs();
    return int'({bus.done, bus.player_win_light, bus.dealer_win_light,
                 bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
                 bus.load_dcard2, bus.load_pcard3, bus.load_dcard3});
  endfunction

  localparam int O_P1 = 9'b000_100000;
  localparam int O_D1 = 9'b000_010000;
  localparam int O_P2 = 9'b000_001000;
  localparam int O_D2 = 9'b000_000100;
  localparam int O_P3 = 9'b000_000010;
  localparam int O_D3 = 9'b000_000001;
  localparam int O_EV = 9'b000_000000;

  // Banker draw set as a bitmask over the player's third-card value 0..9
  function automatic bit ref_banker_draw(input int dsc, input int v);
    logic [9:0] mask;
    case (dsc)
      0, 1, 2: mask = 10'h3FF;
      3:       mask = 10'h2FF;
      4:       mask = 10'h0FC;
      5:       mask = 10'h0F0;
      6:       mask = 10'h0C0;
      default: mask = 10'h000;
    endcase
    return mask[v];
  endfunction

  task automatic do_reset();
    @(negedge slow_clock);
    resetb = 1'b0;
    step   = 1'b0;
    @(posedge slow_clock);
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      step = 1'b1;
      @(posedge slow_clock);
      @(negedge slow_clock);
    end
    step = 1'b0;
  endtask

  // Plays one full round; c[] = p1,d1,p2,d2,p3,d3
  task automatic run_round(input logic [3:0] c [6], input int stall_pct);
    int seq[$];
    int pv, dv, idx, cycles, v3;
    bit natural;
    for (int i = 0; i < 6; i++) deal[i] = c[i];
    do_reset();

    pv = (cval(c[0]) + cval(c[2])) % 10;
    dv = (cval(c[1]) + cval(c[3])) % 10;
    seq = '{O_P1, O_D1, O_P2, O_D2, O_EV};
    natural = (pv >= 8) || (dv >= 8);
    if (!natural) begin
      if (pv <= 5) begin
        v3 = cval(c[4]);
        pv = (pv + v3) % 10;
        seq.push_back(O_P3);
        seq.push_back(O_EV);
        if (ref_banker_draw(dv, v3)) begin
          seq.push_back(O_D3);
          dv = (dv + cval(c[5])) % 10;
        end
      end else if (dv <= 5) begin
        seq.push_back(O_D3);
        dv = (dv + cval(c[5])) % 10;
      end
    end

    idx = 0;
    cycles = 0;
    while (idx < seq.size()) begin
      check_eq($sformatf("round_out[%0d]", idx), outs(), seq[idx]);
      step = ($urandom_range(99) >= stall_pct);
      @(posedge slow_clock);
      if (step) idx++;
      @(negedge slow_clock);
      cycles++;
      if (cycles > 400) begin
        check_eq("round_timeout", 1, 0);
        break;
      end
    end
    step = 1'b0;
    check_eq("round_result", outs(),
             int'({1'b1, pv >= dv, dv >= pv, 6'b0}));
    $display("round cards=%0d,%0d,%0d,%0d,%0d,%0d steps=%0d p=%0d d=%0d",
             c[0], c[1], c[2], c[3], c[4], c[5], seq.size(), pv, dv);
  endtask

  logic [3:0] cards [6];
  logic [3:0] plan [4][6];

  initial begin
    plan[0] = '{4'd4, 4'd10, 4'd5, 4'd3, 4'd0, 4'd0};   // natural
    plan[1] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd8, 4'd0};    // banker 3 stands vs 8
    plan[2] = '{4'd3, 4'd2, 4'd3, 4'd3, 4'd0, 4'd1};    // player stands, banker draws
    plan[3] = '{4'd2, 4'd3, 4'd2, 4'd3, 4'd7, 4'd13};   // banker 6 draws vs 7

    for (int t = 0; t < 4; t++) run_round(plan[t], 0);

    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < 6; i++) cards[i] = 4'($urandom_range(13, 1));
      run_round(cards, 30);
    end

    // Stall in P3, then asynchronous reset between edges
    for (int i = 0; i < 6; i++) deal[i] = plan[3][i];
    do_reset();
    advance(5);
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_p3", outs(), O_P3);
      @(posedge slow_clock);
      @(negedge slow_clock);
    end
    #2 resetb = 1'b0;
    #1 check_eq("async_reset", outs(), O_P1);
    #1 resetb = 1'b1;
    #1 check_eq("after_release", outs(), O_P1);
    @(negedge slow_clock);
    advance(1);
    check_eq("restart_d1", outs(), O_D1);
    $display("stall/reset sequence complete");

    // Banker table sweep at EVAL2 with forced scores
    force_en = 1'b1;
    for (int pc = 0; pc <= 13; pc++) begin
      for (int ds = 0; ds <= 7; ds++) begin
        bit exp_draw;
        f_ps = 0; f_ds = 0; f_pc3 = 0;
        do_reset();
        advance(6);
        check_eq("at_eval2", outs(), O_EV);
        f_ds = 4'(ds);
        f_pc3 = 4'(pc);
        advance(1);
        exp_draw = ref_banker_draw(ds, cval(pc));
        check_eq($sformatf("banker_draw[d%0d,c%0d]", ds, pc),
                 int'({bus.done, bus.load_dcard3}), int'({!exp_draw, exp_draw}));
        $display("table dscore=%0d pcard3=%0d draw=%0d", ds, pc, exp_draw);
      end
    end
    force_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
